// File: rtl/cr_prefix_attach_pfd_arb_pkg.sv
// Shared types for the prefix-attach PFD path: descriptor layout, table depth
// and the register-access state encoding used by the SRAM arbiter.
package cr_prefix_attachPKG;

  localparam int CR_PREFIX_PFD_ENTRIES = 256;
  localparam int CR_PREFIX_PFD_ADDR_W  = $clog2(CR_PREFIX_PFD_ENTRIES);

  typedef struct packed {
    logic        valid;
    logic [6:0]  prefix_len;
    logic [23:0] next_hop;
    logic [31:0] prefix;
  } pfd_t;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_PEND = 2'd1,
    R_WAIT = 2'd2,
    R_ACK  = 2'd3
  } reg_st_e;

endpackage

// File: rtl/cr_prefix_attach_pfd_arb.sv
// PFD SRAM port arbiter: core reads win by default, register-bus indirect
// accesses are squeezed in on idle core cycles or after a bounded core streak.
module cr_prefix_attach_pfd_arb
  import cr_prefix_attachPKG::*;
#(
  parameter int ADDR_W          = CR_PREFIX_PFD_ADDR_W,
  parameter int DATA_W          = $bits(pfd_t),
  parameter int MAX_CORE_STREAK = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              core_cs,
  input  logic [ADDR_W-1:0] core_addr,
  output logic              core_yield,
  output logic [DATA_W-1:0] core_dout,
  output logic              core_dout_valid,
  input  logic              reg_req,
  input  logic              reg_wr,
  input  logic [ADDR_W-1:0] reg_addr,
  input  logic [DATA_W-1:0] reg_wdata,
  output logic              reg_ack,
  output logic [DATA_W-1:0] reg_rdata,
  output logic              mem_cs,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int            SW         = $clog2(MAX_CORE_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_CORE_STREAK);

  reg_st_e           r_reg_st;
  reg_st_e           w_reg_st_next;
  logic [SW-1:0]     r_streak;
  logic              r_reg_wr;
  logic              r_core_rd_q;
  logic              r_core_dout_valid;
  logic [DATA_W-1:0] r_core_dout;
  logic [DATA_W-1:0] r_reg_rdata;
  logic              w_reg_grant;
  logic              w_core_grant;

  // Grants are masked by rst so the SRAM sees no strobe while held in reset.
  assign w_reg_grant  = !rst && (r_reg_st == R_PEND) && (!core_cs || (r_streak == STREAK_MAX));
  assign w_core_grant = !rst && core_cs && !w_reg_grant;

  assign mem_cs    = w_reg_grant | w_core_grant;
  assign mem_we    = w_reg_grant & reg_wr;
  assign mem_addr  = w_reg_grant ? reg_addr : (w_core_grant ? core_addr : '0);
  assign mem_wdata = w_reg_grant ? reg_wdata : '0;

  assign core_yield      = core_cs & w_reg_grant;
  assign core_dout       = r_core_dout;
  assign core_dout_valid = r_core_dout_valid;
  assign reg_ack         = (r_reg_st == R_ACK);
  assign reg_rdata       = r_reg_rdata;

  always_comb begin
    w_reg_st_next = r_reg_st;
    case (r_reg_st)
      R_IDLE:  if (reg_req) w_reg_st_next = R_PEND;
      R_PEND:  if (w_reg_grant) w_reg_st_next = R_WAIT;
      R_WAIT:  w_reg_st_next = R_ACK;
      R_ACK:   w_reg_st_next = R_IDLE;
      default: w_reg_st_next = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_reg_st <= R_IDLE;
    end else begin
      r_reg_st <= w_reg_st_next;
    end
  end

  // Streak only counts core wins that actually held off a pending register access.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_streak <= '0;
    end else if (w_reg_grant || (r_reg_st != R_PEND)) begin
      r_streak <= '0;
    end else if (w_core_grant && (r_streak != STREAK_MAX)) begin
      r_streak <= r_streak + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_reg_wr    <= 1'b0;
      r_reg_rdata <= '0;
    end else begin
      if (w_reg_grant) begin
        r_reg_wr <= reg_wr;
      end
      if ((r_reg_st == R_WAIT) && !r_reg_wr) begin
        r_reg_rdata <= mem_rdata;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_core_rd_q       <= 1'b0;
      r_core_dout_valid <= 1'b0;
      r_core_dout       <= '0;
    end else begin
      r_core_rd_q       <= w_core_grant;
      r_core_dout_valid <= r_core_rd_q;
      if (r_core_rd_q) begin
        r_core_dout <= mem_rdata;
      end
    end
  end

endmodule

// File: doc/cr_prefix_attach_pfd_arb.md
# cr_prefix_attach_pfd_arb

Arbitrated read/write port for the prefix-descriptor (PFD) SRAM, sitting directly upstream of the prefix-attach core's `pfd_mem_*` interface. It services the core's single-cycle read requests with priority, and interleaves register-bus indirect reads and writes, signalling `yield` whenever a core request loses the SRAM cycle. A starvation counter guarantees register access under sustained core traffic.

## Interface
Parameters:
- `ADDR_W`, 8, SRAM address width; equals log2 of `CR_PREFIX_PFD_ENTRIES`.
- `DATA_W`, 64, PFD entry width; equals `$bits(pfd_t)`.
- `MAX_CORE_STREAK`, 4, consecutive core grants allowed while a register request waits (≥1).

Ports:
- `clk`  in  1  single clock.
- `rst`  in  1  asynchronous, active-high reset.
- `core_cs`  in  1  core read request for this cycle.
- `core_addr`  in  ADDR_W  core read address.
- `core_yield`  out  1  core request not granted this cycle; the core re-issues.
- `core_dout`  out  DATA_W  last core read data, held.
- `core_dout_valid`  out  1  one-cycle pulse when `core_dout` updates.
- `reg_req`  in  1  register access request; level, held until `reg_ack`.
- `reg_wr`  in  1  1 = write, 0 = read; stable while `reg_req` is high.
- `reg_addr`  in  ADDR_W  register access address; stable while `reg_req` is high.
- `reg_wdata`  in  DATA_W  write data; stable while `reg_req` is high.
- `reg_ack`  out  1  one-cycle completion pulse.
- `reg_rdata`  out  DATA_W  read data, valid with `reg_ack` for reads; held otherwise.
- `mem_cs`, `mem_we`  out  1  SRAM strobe and write enable.
- `mem_addr`  out  ADDR_W  SRAM address.
- `mem_wdata`  out  DATA_W  SRAM write data.
- `mem_rdata`  in  DATA_W  SRAM read data, valid one cycle after a read strobe.

## Operation
- The grant decision is combinational each cycle. Register wins if `reg_st==R_PEND` and either `!core_cs` or `streak==MAX_CORE_STREAK`. Otherwise the core wins if `core_cs` is high.
- The core grant drives `mem_cs=1`, `mem_we=0`, `mem_addr=core_addr`.
- The register grant drives `mem_cs=1`, `mem_we=reg_wr`, with `reg_addr`/`reg_wdata`.
- `core_yield = core_cs & reg_grant`.
- `streak` counter (width clog2(MAX_CORE_STREAK+1)):
  - increments on a core grant while `reg_st==R_PEND`;
  - clears on a register grant or when `reg_st!=R_PEND`;
  - saturates at MAX_CORE_STREAK.
- Register FSM `reg_st`:
  - `R_IDLE` → `R_PEND` when `reg_req`.
  - `R_PEND` → `R_WAIT` on register grant.
  - `R_WAIT` → `R_ACK`: captures `mem_rdata` into `reg_rdata` if the access was a read.
  - `R_ACK` asserts `reg_ack` for one cycle, then goes to `R_IDLE`.
  - `reg_req` is sampled again only in `R_IDLE`, so one access produces exactly one ack even if the requester is slow to drop `reg_req`.
- Core read pipeline: a `core_rd_q` flag is set on the grant cycle. The next cycle captures `mem_rdata` into a holding register. `core_dout`/`core_dout_valid` come from that register.
- Register reads never disturb `core_dout`.
- Writes to the address currently being read by the core are not forwarded. The core observes the pre-write value if its grant preceded the write.

## Timing
- Reset values:
  - `core_dout=0`, `core_dout_valid=0`, `reg_ack=0`, `reg_rdata=0`.
  - `reg_st=R_IDLE`, `streak=0`, `core_rd_q=0`.
  - `mem_*` and `core_yield` are combinational and evaluate to 0 under reset (grants are masked by `rst`).
- Core read granted at cycle T: `mem_cs` at T, `mem_rdata` at T+1, `core_dout_valid` pulse and new `core_dout` at T+2. Back-to-back grants give one result per cycle.
- Register access with `reg_req` rising at T and no core traffic: `R_PEND` at T+1, grant at T+1, capture at T+2, `reg_ack` at T+3.
- Register access under continuous `core_cs`:
  - core grants at T+1..T+MAX_CORE_STREAK;
  - register grant at T+1+MAX_CORE_STREAK, with `core_yield` high that cycle;
  - `reg_ack` two cycles after the register grant.
- Simultaneous `core_cs` and a fresh `reg_req` (in `R_IDLE`): the core is granted and there is no yield.
- Reset mid-operation:
  - in-flight core and register results are discarded;
  - no `reg_ack` is issued;
  - the requester must re-present `reg_req` after reset deasserts.

## Structure
- Shared package `cr_prefix_attachPKG` holds:
  - the `reg_st` enum (`R_IDLE`, `R_PEND`, `R_WAIT`, `R_ACK`);
  - reuse of the existing `pfd_t`, with `DATA_W` tied to `$bits(pfd_t)`.
- No sub-module is needed; grant logic, FSM and capture registers live in one module.
- A PHD instance reuses the same module with PHD widths.

## Test plan
- Reset, then a core read of addr 0x05 (SRAM holds 0xA5A5) → `mem_cs` at T, `core_dout_valid` at T+2 with `core_dout=0xA5A5`, `core_yield` never high.
- Idle core, register write 0x12 ← 0xDEAD, then register read 0x12 → each `reg_ack` 3 cycles after `reg_req`; read returns 0xDEAD.
- `core_cs` held high 20 cycles with `MAX_CORE_STREAK=4`, plus a register read → exactly one `core_yield` cycle, on the 5th cycle after `R_PEND`; `reg_ack` 2 cycles later; all 19 granted core reads return correct data.
- `core_cs` and `reg_req` rising in the same cycle → core granted first and no yield; register granted on the next idle core cycle.
- `reg_req` held high 10 cycles after ack → exactly one ack per `R_IDLE` entry; no duplicate SRAM writes beyond re-requests.
- Assert `rst` in `R_WAIT` and with a core read in flight → no `reg_ack`, no `core_dout_valid`; all outputs return to reset values within the reset cycle.
